// File: rtl/exe_pkg.sv
// Shared types and sizing for the execute stage: ALU op encoding, MUL sequencer
// states and the registered control bundle.
package exe_pkg;

    localparam int LANES = 4;
    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_ROL   = 4'd7,
        OP_ROR   = 4'd8,
        OP_MUL   = 4'd9,
        OP_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic             result_src;
        logic             update_count;
        logic             branch_taken;
        logic [3:0]       rd;
        logic [WIDTH-1:0] scalar;
    } ctrl_t;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU. MUL is not handled here (it shares one multiplier
// in the stage); unsupported codes give zero.
module vec_lane_alu
    import exe_pkg::*;
(
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    logic [4:0] sh;
    logic [4:0] sh_inv;

    // Amount 0 gives sh_inv=16, which shifts the wrap-around term fully out.
    assign sh     = {1'b0, b[3:0]};
    assign sh_inv = 5'(WIDTH) - sh;

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SHL:   res = a << sh;
            OP_SHR:   res = a >> sh;
            OP_ROL:   res = (a << sh) | (a >> sh_inv);
            OP_ROR:   res = (a >> sh) | (a << sh_inv);
            OP_PASSB: res = b;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Vector execute stage: four lane ALUs plus a shared multiplier that walks the
// lanes over four cycles, stalling the upstream register with stop.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] op01_in,
    input  logic [15:0] op11_in,
    input  logic [15:0] op21_in,
    input  logic [15:0] op31_in,
    input  logic [15:0] op02_in,
    input  logic [15:0] op12_in,
    input  logic [15:0] op22_in,
    input  logic [15:0] op32_in,
    input  logic [15:0] op1_in,
    input  logic [15:0] op2_in,
    input  logic [3:0]  rd_in,
    input  logic [3:0]  aluControl_in,
    input  logic        regWrite_in,
    input  logic        memWrite_in,
    input  logic        branch_in,
    input  logic        resultSrc_in,
    input  logic        updateCount_in,
    output logic [15:0] res0_out,
    output logic [15:0] res1_out,
    output logic [15:0] res2_out,
    output logic [15:0] res3_out,
    output logic [15:0] scalar_out,
    output logic [3:0]  rd_out,
    output logic        regWrite_out,
    output logic        memWrite_out,
    output logic        resultSrc_out,
    output logic        updateCount_out,
    output logic        branchTaken_out,
    output logic        stop
);

    logic [LANES-1:0][WIDTH-1:0] op_a, op_b, alu_res, res_d, res_q;
    logic [LANES-2:0][WIDTH-1:0] prod_q;
    ctrl_t                       ctrl_in, ctrl_d, ctrl_q;
    state_e                      state;
    logic [1:0]                  cnt, lane_sel;
    logic [WIDTH-1:0]            mul_lo;
    logic                        mul_req, mul_done;

    assign op_a = {op31_in, op21_in, op11_in, op01_in};
    assign op_b = {op32_in, op22_in, op12_in, op02_in};

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            vec_lane_alu u_alu (
                .op  (aluControl_in),
                .a   (op_a[i]),
                .b   (op_b[i]),
                .res (alu_res[i])
            );
        end
    endgenerate

    assign mul_req  = (aluControl_in == OP_MUL) && regWrite_in;
    assign mul_done = (state == BUSY) && (cnt == 2'd3);
    assign lane_sel = (state == BUSY) ? cnt : 2'd0;
    // Low half of the 16x16 product is all that is ever kept.
    assign mul_lo   = op_a[lane_sel] * op_b[lane_sel];

    assign stop = !reset && (((state == IDLE) && mul_req) ||
                             ((state == BUSY) && (cnt != 2'd3)));

    always_comb begin
        ctrl_in = '{reg_write:    regWrite_in,
                    mem_write:    memWrite_in,
                    result_src:   resultSrc_in,
                    update_count: updateCount_in,
                    branch_taken: branch_in && (op1_in == op2_in),
                    rd:           rd_in,
                    scalar:       op1_in + op2_in};
        res_d  = alu_res;
        ctrl_d = ctrl_in;
        if (mul_done) begin
            res_d = {mul_lo, prod_q[2], prod_q[1], prod_q[0]};
        end else if (stop || (aluControl_in == OP_MUL)) begin
            // Stall cycles and MULs without a write become bubbles.
            res_d  = '0;
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            prod_q <= '0;
            res_q  <= '0;
            ctrl_q <= '0;
        end else begin
            res_q  <= res_d;
            ctrl_q <= ctrl_d;
            case (state)
                IDLE: begin
                    if (mul_req) begin
                        prod_q[0] <= mul_lo;
                        cnt       <= 2'd1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 2'd3) begin
                        cnt   <= 2'd0;
                        state <= IDLE;
                    end else begin
                        prod_q[cnt] <= mul_lo;
                        cnt         <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res0_out        = res_q[0];
    assign res1_out        = res_q[1];
    assign res2_out        = res_q[2];
    assign res3_out        = res_q[3];
    assign scalar_out      = ctrl_q.scalar;
    assign rd_out          = ctrl_q.rd;
    assign regWrite_out    = ctrl_q.reg_write;
    assign memWrite_out    = ctrl_q.mem_write;
    assign resultSrc_out   = ctrl_q.result_src;
    assign updateCount_out = ctrl_q.update_count;
    assign branchTaken_out = ctrl_q.branch_taken;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: cycle-level behavioural model plus directed
// literal checks and randomized traffic.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic [15:0] op1, op2;
    logic [3:0]  rd, aluc;
    logic        rw, mw, br, rs, uc;
    logic [15:0] res0, res1, res2, res3, scalar;
    logic [3:0]  rd_o;
    logic        rw_o, mw_o, rs_o, uc_o, bt_o, stop;

    typedef struct packed {
        logic [15:0] r0, r1, r2, r3, sc;
        logic [3:0]  rd;
        logic        rw, mw, rs, uc, bt;
    } out_t;

    int   checks   = 0;
    int   failures = 0;
    int   mc       = 0;
    out_t exp_q    = '0;
    logic exp_stop = 1'b0;
    out_t nxt, act;
    logic st;
    logic [15:0] lr[4];

    exe_stage dut (
        .clk(clk), .reset(reset),
        .op01_in(va[0]), .op11_in(va[1]), .op21_in(va[2]), .op31_in(va[3]),
        .op02_in(vb[0]), .op12_in(vb[1]), .op22_in(vb[2]), .op32_in(vb[3]),
        .op1_in(op1), .op2_in(op2), .rd_in(rd), .aluControl_in(aluc),
        .regWrite_in(rw), .memWrite_in(mw), .branch_in(br),
        .resultSrc_in(rs), .updateCount_in(uc),
        .res0_out(res0), .res1_out(res1), .res2_out(res2), .res3_out(res3),
        .scalar_out(scalar), .rd_out(rd_o), .regWrite_out(rw_o),
        .memWrite_out(mw_o), .resultSrc_out(rs_o), .updateCount_out(uc_o),
        .branchTaken_out(bt_o), .stop(stop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    function automatic logic [15:0] lane_fn(input int op, input int unsigned x, input int unsigned y);
        int unsigned s;
        int unsigned r;
        s = y % 16;
        case (op)
            0:  r = x + y;
            1:  r = x - y;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = x << s;
            6:  r = x >> s;
            7:  r = (x << s) | (x >> (16 - s));
            8:  r = (x >> s) | (x << (16 - s));
            9:  r = x * y;
            10: r = y;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic out_t actual();
        out_t o;
        o = '{r0: res0, r1: res1, r2: res2, r3: res3, sc: scalar, rd: rd_o,
              rw: rw_o, mw: mw_o, rs: rs_o, uc: uc_o, bt: bt_o};
        return o;
    endfunction

    // Model: mc counts cycles spent inside a multiply sequence (0 = not multiplying).
    always @(negedge clk) begin
        act = actual();
        if (reset) begin
            mc       = 0;
            exp_q    = '0;
            exp_stop = 1'b0;
            chk("reset_stop", {127'd0, stop}, 128'd0);
            chk("reset_outputs", {39'd0, act}, 128'd0);
        end else begin
            nxt = '0;
            st  = 1'b0;
            if (mc == 0 && aluc == 4'd9 && rw) begin
                st = 1'b1;
                mc = 1;
            end else if (mc == 1 || mc == 2) begin
                st = 1'b1;
                mc = mc + 1;
            end else if (mc == 0 && aluc == 4'd9) begin
                st = 1'b0;
            end else begin
                for (int k = 0; k < 4; k++)
                    lr[k] = lane_fn((mc == 3) ? 9 : int'(aluc), va[k], vb[k]);
                nxt = '{r0: lr[0], r1: lr[1], r2: lr[2], r3: lr[3], sc: op1 + op2, rd: rd,
                        rw: rw, mw: mw, rs: rs, uc: uc, bt: br && (op1 == op2)};
                mc = 0;
            end
            chk("stop", {127'd0, stop}, {127'd0, st});
            chk("outputs", {39'd0, act}, {39'd0, exp_q});
            exp_q    = nxt;
            exp_stop = st;
        end
    end

    // a and b list lane 0 in the top 16 bits.
    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic w);
        for (int k = 0; k < 4; k++) begin
            va[k] = a[63-16*k -: 16];
            vb[k] = b[63-16*k -: 16];
        end
        aluc = op;
        rw   = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'(2 ** $urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    int nstop;

    initial begin
        reset = 1'b1;
        drive(4'd0, 64'd0, 64'd0, 1'b0);
        op1 = '0; op2 = '0; rd = '0; mw = 0; br = 0; rs = 0; uc = 0;
        #2;
        chk("reset_state", {39'd0, actual(), stop}, 128'd0);
        tick();
        tick();
        reset = 1'b0;

        drive(4'd0, 64'hFFFF_0001_1234_8000, 64'h0001_0001_1111_8000, 1'b1);
        rd = 4'd3;
        tick();
        chk("add_res", {res0, res1, res2, res3}, 64'h0000_0002_2345_0000);
        chk("add_regwrite", {127'd0, rw_o}, 128'd1);
        chk("add_rd", {124'd0, rd_o}, 128'd3);

        // Asynchronous reset between edges with nonzero outputs and a MUL pending.
        drive(4'd9, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midcycle_reset", {39'd0, actual(), stop}, 128'd0);
        tick();
        reset = 1'b0;

        drive(4'd7, 64'h8001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b1);
        tick();
        chk("rol", {112'd0, res0}, 128'h0003);
        drive(4'd6, 64'h0000_8000_0000_0000, 64'h0000_0004_0000_0000, 1'b1);
        tick();
        chk("shr", {112'd0, res1}, 128'h0800);
        drive(4'd8, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0000, 1'b1);
        tick();
        chk("ror0", {112'd0, res2}, 128'h0001);

        drive(4'd0, 64'd0, 64'd0, 1'b0);
        br = 1'b1; op1 = 16'h0040; op2 = 16'h0040;
        tick();
        chk("branch_eq", {111'd0, bt_o, scalar}, {111'd1, 16'h0080});
        op2 = 16'h0041;
        tick();
        chk("branch_ne", {111'd0, bt_o, scalar}, {111'd0, 16'h0081});
        br = 1'b0;

        drive(4'd9, 64'h0003_0100_FFFF_1234, 64'h0005_0100_FFFF_0002, 1'b1);
        nstop = 0;
        repeat (4) begin
            #2;
            nstop += int'(stop);
            tick();
        end
        chk("mul_stop_cycles", 128'(nstop), 128'd3);
        chk("mul_res", {res0, res1, res2, res3}, 64'h000F_0000_0001_2468);
        chk("mul_regwrite", {127'd0, rw_o}, 128'd1);
        #1;
        chk("b2b_stop", {127'd0, stop}, 128'd1);
        drive(4'd9, 64'h0002_0010_8000_0007, 64'h0003_0010_0002_0009, 1'b1);
        repeat (4) tick();
        chk("mul2_res", {res0, res1, res2, res3}, 64'h0006_0100_0000_003F);

        drive(4'd9, 64'h0003_0003_0003_0003, 64'h0005_0005_0005_0005, 1'b0);
        #1;
        chk("mul_nowrite_stop", {127'd0, stop}, 128'd0);
        tick();
        chk("mul_nowrite_res", {39'd0, actual()}, 128'd0);

        drive(4'd12, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
        rd = 4'd5;
        tick();
        chk("op12_res", {res0, res1, res2, res3}, 64'd0);
        chk("op12_ctrl", {123'd0, rw_o, rd_o}, {123'd1, 4'd5});

        // Abort a multiply after two cycles; nothing from it may surface.
        drive(4'd9, 64'h0003_0100_FFFF_1234, 64'h0005_0100_FFFF_0002, 1'b1);
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("abort_reset", {39'd0, actual(), stop}, 128'd0);
        tick();
        drive(4'd0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1);
        reset = 1'b0;
        tick();
        chk("post_abort_add", {res0, res1, res2, res3}, 64'h0011_0022_0033_0044);
        tick();
        chk("post_abort_stop", {127'd0, stop}, 128'd0);

        for (int n = 0; n < 800; n++) begin
            if (!exp_stop) begin
                aluc = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
                rw   = 1'($urandom_range(0, 4) != 0);
                for (int k = 0; k < 4; k++) begin
                    va[k] = rnd16();
                    vb[k] = rnd16();
                end
                op1 = rnd16();
                op2 = ($urandom_range(0, 3) == 0) ? op1 : rnd16();
                rd  = 4'($urandom);
                mw  = 1'($urandom);
                br  = 1'($urandom);
                rs  = 1'($urandom);
                uc  = 1'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 op01_in, op11_in, op21_in, op31_in  input  16 each  vector operand A, lanes 0-3.
REQ-004 op02_in, op12_in, op22_in, op32_in  input  16 each  vector operand B, lanes 0-3.
REQ-005 op1_in, op2_in  input  16 each  scalar operands.
REQ-006 rd_in  input  4  destination register.
REQ-007 aluControl_in  input  4  operation code, encoding per REQ-021.
REQ-008 regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in  input  1 each  control bits from the ID/EXE register.
REQ-009 res0_out..res3_out  output  16 each  registered vector result, lanes 0-3.
REQ-010 scalar_out  output  16  registered op1_in+op2_in (memory address).
REQ-011 rd_out  output  4  registered rd_in.
REQ-012 regWrite_out, memWrite_out, resultSrc_out, updateCount_out  output  1 each  registered control bits.
REQ-013 branchTaken_out  output  1  registered branch_in & (op1_in == op2_in).
REQ-014 stop  output  1  combinational stall request to the ID/EXE register (hold when 1).

Function
REQ-020 Output register SHALL load every cycle; single-cycle ops have 1-cycle latency (input at edge N -> output after edge N+1).
REQ-021 Encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 ROL, 8 ROR, 9 MUL, 10 PASSB; 11-15 give result 0x0000 with control bits still passed.
REQ-022 ADD/SUB/MUL wrap modulo 2^16; MUL keeps the low 16 bits of the 16x16 product.
REQ-023 Shift and rotate amount SHALL be operand B[3:0] of the same lane; amount 0 returns A unchanged.
REQ-024 A MUL request is aluControl_in==9 with regWrite_in==1; MUL SHALL use one shared 16x16 multiplier, one lane per cycle, lanes 0..3 in order.
REQ-025 FSM states IDLE and BUSY; 2-bit lane counter cnt.
REQ-026 IDLE + MUL request: compute lane 0, cnt<=1, go to BUSY, stop=1.
REQ-027 BUSY, cnt<3: compute lane cnt, cnt<=cnt+1, stop=1.
REQ-028 BUSY, cnt==3: compute lane 3, load all four products and controls into the output register, go to IDLE, stop=0.
REQ-029 MUL occupancy SHALL be 4 cycles, with stop high for exactly 3 consecutive cycles.
REQ-030 While stop=1, the output register SHALL load a bubble: all results 0, all control outputs 0, rd_out 0.
REQ-031 Operands SHALL be held stable by the upstream register while stop=1; exe_stage SHALL NOT latch them.
REQ-032 A MUL with regWrite_in==0 SHALL be treated as a bubble: no stall, result 0.
REQ-033 A back-to-back MUL on the cycle after completion SHALL start a new sequence from IDLE with no idle gap.

Reset
REQ-040 On reset assertion: state=IDLE, cnt=0, stop=0, and all registered outputs 0x0/0, independent of clk.
REQ-041 Reset during BUSY SHALL abort the MUL; partial products are discarded and no result is emitted.

Structure
REQ-050 Package exe_pkg SHALL hold alu_op_e (the REQ-021 encoding), state_e {IDLE,BUSY}, LANES=4 and WIDTH=16.
REQ-051 Sub-module vec_lane_alu SHALL be a combinational single-lane ALU for codes 0-8 and 10, instanced 4 times; MUL stays in exe_stage.

Verification
REQ-060 Assert reset mid-cycle -> all outputs 0 and stop 0 immediately, without a clock edge.
REQ-061 ADD with A={FFFF,0001,1234,8000}, B={0001,0001,1111,8000} -> res={0000,0002,2345,0000} one cycle later, regWrite_out=1.
REQ-062 ROL lane0 A=8001 B=0001 -> 0003; SHR lane1 A=8000 B=0004 -> 0800; ROR lane2 A=0001 B=0000 -> 0001.
REQ-063 MUL with A={0003,0100,FFFF,1234}, B={0005,0100,FFFF,0002} -> stop=1 for 3 cycles with bubbles, then res={000F,0000,0001,2468} and stop=0.
REQ-064 branch_in=1, op1=op2=0040 -> branchTaken_out=1, scalar_out=0080; with op2=0041 -> branchTaken_out=0, scalar_out=0081.
REQ-065 Reset after 2 MUL cycles, then release with an ADD presented -> no MUL result ever appears; ADD result appears 1 cycle after release.
